pll_phase_cal: RTL and testbench

Calibration controller for the SDRAM clock PLL's dynamic phase setting. It sequences PLL reset and lock, then sweeps every phase step of the PLL's PSDA input. At each step it hands a pass/fail test to the SDRAM tester and records the result. It then selects the centre of the longest passing window and keeps the PLL there. It sits between the rPLL instance (built with dynamic phase enabled) and the SDRAM test/controller logic, so the fixed phase constant is replaced by a per-board calibrated value.

---
 rtl/pll_phase_cal_pkg.sv | 15 +
 rtl/pll_phase_cal_if.sv | 15 +
 rtl/pll_phase_cal_window_search.sv | 57 +++++
 rtl/pll_phase_cal.sv | 114 +++++++++++
 tb/tb_pll_phase_cal.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/pll_phase_cal_pkg.sv
// pll_phase_cal_pkg: shared FSM state encoding and default calibration constants
package pll_phase_cal_pkg;
  typedef enum logic [2:0] {
    S_PLLRST, S_LOCK, S_SETPH, S_SETTLE, S_TEST, S_WAIT, S_EVAL, S_DONE
  } state_t;
  localparam int DEF_PHASE_BITS = 4;
  localparam logic [3:0] DEF_DEFAULT_PHASE = 4'b1000;
  localparam int DEF_PLL_RST_CYCLES = 16;
  localparam int DEF_LOCK_TIMEOUT = 65535;
  localparam int DEF_SETTLE_CYCLES = 256;
  localparam int DEF_TEST_TIMEOUT = 1048575;
  function automatic int max_of(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/pll_phase_cal_if.sv
// pll_phase_cal_if: PLL control, tester handshake and calibration status bundle
interface pll_phase_cal_if #(parameter int PHASE_BITS = 4);
  logic pll_lock, pll_reset, cal_start, test_start, test_done, test_pass;
  logic cal_busy, cal_done, cal_fail;
  logic [PHASE_BITS-1:0] psda, win_lo, win_hi;
  logic [2**PHASE_BITS-1:0] pass_map;
  modport master (
    input pll_lock, cal_start, test_done, test_pass,
    output pll_reset, psda, test_start, cal_busy, cal_done, cal_fail, pass_map, win_lo, win_hi
  );
  modport slave (
    output pll_lock, cal_start, test_done, test_pass,
    input pll_reset, psda, test_start, cal_busy, cal_done, cal_fail, pass_map, win_lo, win_hi
  );
endinterface

// File: rtl/pll_phase_cal_window_search.sv
// pll_window_search: serial longest-passing-run finder, one map bit per cycle, lowest start wins ties
module pll_window_search #(
  parameter int PHASE_BITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2**PHASE_BITS-1:0] pass_map,
  input  logic                    start,
  output logic [PHASE_BITS-1:0]   lo,
  output logic [PHASE_BITS-1:0]   hi,
  output logic                    found,
  output logic                    done
);
  localparam int N = 2 ** PHASE_BITS;
  logic [PHASE_BITS:0] i, cur_len, best_len, hi_w;
  logic [PHASE_BITS-1:0] cur_lo;
  logic busy, last, run, better;
  assign last = i == (PHASE_BITS+1)'(N);
  assign run = pass_map[i[PHASE_BITS-1:0]] && !last;
  assign better = cur_len > best_len;
  assign hi_w = {1'b0, lo} + best_len - 1'b1;
  assign hi = hi_w[PHASE_BITS-1:0];
  assign found = best_len != '0;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i <= '0;
      cur_len <= '0;
      best_len <= '0;
      cur_lo <= '0;
      lo <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        i <= '0;
        cur_len <= '0;
        best_len <= '0;
        lo <= '0;
        busy <= 1'b1;
      end else if (busy) begin
        i <= i + 1'b1;
        cur_len <= run ? cur_len + 1'b1 : '0;
        if (run && cur_len == '0) cur_lo <= i[PHASE_BITS-1:0];
        // a run is closed by the first failing bit or by running off the top index
        if (!run && better) begin
          best_len <= cur_len;
          lo <= cur_lo;
        end
        if (last) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/pll_phase_cal.sv
// pll_phase_cal: sequences PLL reset/lock, sweeps PSDA phases against the SDRAM tester, parks at the window centre
module pll_phase_cal
  import pll_phase_cal_pkg::*;
#(
  parameter int PHASE_BITS = DEF_PHASE_BITS,
  parameter logic [PHASE_BITS-1:0] DEFAULT_PHASE = PHASE_BITS'(DEF_DEFAULT_PHASE),
  parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int TEST_TIMEOUT = DEF_TEST_TIMEOUT
) (
  input logic clk,
  input logic reset,
  pll_phase_cal_if.master bus
);
  localparam int CW = $clog2(max_of(max_of(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                    max_of(SETTLE_CYCLES, TEST_TIMEOUT)) + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [PHASE_BITS-1:0] idx, ws_lo, ws_hi;
  logic [PHASE_BITS:0] mid;
  logic lock_meta, lock_s, ws_start, ws_found, ws_done, lost, restart, got;
  assign lost = state != S_PLLRST && state != S_LOCK && !lock_s;
  assign restart = lost || (bus.cal_start && state != S_PLLRST);
  // a done pulse coinciding with our own test_start belongs to no test we issued
  assign got = bus.test_done && !bus.test_start;
  assign mid = {1'b0, ws_lo} + {1'b0, ws_hi};
  pll_window_search #(.PHASE_BITS(PHASE_BITS)) u_search (
    .clk(clk), .reset(reset), .pass_map(bus.pass_map), .start(ws_start),
    .lo(ws_lo), .hi(ws_hi), .found(ws_found), .done(ws_done)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_PLLRST;
      cnt <= '0;
      idx <= '0;
      lock_meta <= 1'b0;
      lock_s <= 1'b0;
      ws_start <= 1'b0;
      bus.pll_reset <= 1'b1;
      bus.psda <= DEFAULT_PHASE;
      bus.test_start <= 1'b0;
      bus.cal_busy <= 1'b1;
      bus.cal_done <= 1'b0;
      bus.cal_fail <= 1'b0;
      bus.pass_map <= '0;
      bus.win_lo <= '0;
      bus.win_hi <= '0;
    end else begin
      lock_meta <= bus.pll_lock;
      lock_s <= lock_meta;
      ws_start <= 1'b0;
      bus.test_start <= 1'b0;
      if (restart) begin
        state <= S_PLLRST;
        cnt <= '0;
        bus.pll_reset <= 1'b1;
        bus.cal_busy <= 1'b1;
        bus.cal_done <= 1'b0;
        bus.cal_fail <= 1'b0;
        bus.pass_map <= '0;
      end else begin
        case (state)
          S_PLLRST:
            if (cnt == CW'(PLL_RST_CYCLES - 1)) begin
              state <= S_LOCK;
              cnt <= '0;
              bus.pll_reset <= 1'b0;
            end else cnt <= cnt + 1'b1;
          S_LOCK:
            if (lock_s) begin
              state <= S_SETPH;
              idx <= '0;
            end else if (cnt == CW'(LOCK_TIMEOUT)) begin
              state <= S_PLLRST;
              cnt <= '0;
              bus.pll_reset <= 1'b1;
            end else cnt <= cnt + 1'b1;
          S_SETPH: begin
            bus.psda <= idx;
            cnt <= '0;
            state <= S_SETTLE;
          end
          S_SETTLE:
            if (cnt == CW'(SETTLE_CYCLES - 1)) state <= S_TEST;
            else cnt <= cnt + 1'b1;
          S_TEST: begin
            bus.test_start <= 1'b1;
            cnt <= '0;
            state <= S_WAIT;
          end
          S_WAIT:
            if (got || cnt == CW'(TEST_TIMEOUT)) begin
              bus.pass_map[idx] <= got && bus.test_pass;
              state <= &idx ? S_EVAL : S_SETPH;
              ws_start <= &idx;
              idx <= idx + 1'b1;
            end else cnt <= cnt + 1'b1;
          S_EVAL:
            if (ws_done) begin
              state <= S_DONE;
              bus.cal_busy <= 1'b0;
              bus.cal_done <= ws_found;
              bus.cal_fail <= !ws_found;
              bus.win_lo <= ws_found ? ws_lo : '0;
              bus.win_hi <= ws_found ? ws_hi : '0;
              bus.psda <= ws_found ? mid[PHASE_BITS:1] : DEFAULT_PHASE;
            end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pll_phase_cal.sv
// tb_pll_phase_cal: directed calibration scenarios against a PLL lock model and a scripted SDRAM tester
module tb_pll_phase_cal;
  localparam int PB = 4, RST = 4, LTO = 150, SET = 8, TTO = 50;
  logic clk = 1'b0, reset = 1'b1, cal_start = 1'b0;
  logic lock_en = 1'b1, lock_drop = 1'b0, lock_ok = 1'b0;
  logic t_done = 1'b0, t_pass = 1'b0, i_done = 1'b0, i_pass = 1'b0;
  logic [15:0] pattern = '0;
  int no_ans = -1;
  int total = 0, bad = 0;

  pll_phase_cal_if #(.PHASE_BITS(PB)) bus ();
  pll_phase_cal #(
    .PHASE_BITS(PB), .PLL_RST_CYCLES(RST), .LOCK_TIMEOUT(LTO),
    .SETTLE_CYCLES(SET), .TEST_TIMEOUT(TTO)
  ) dut (.clk(clk), .reset(reset), .bus(bus));

  assign bus.pll_lock = lock_ok & !lock_drop;
  assign bus.cal_start = cal_start;
  assign bus.test_done = t_done | i_done;
  assign bus.test_pass = t_pass | i_pass;

  always #5 clk = ~clk;

  // PLL locks 100 cycles after its reset pin is released
  initial begin
    int lk = 0;
    forever begin
      @(negedge clk);
      if (bus.pll_reset || !lock_en) begin
        lk = 0;
        lock_ok = 1'b0;
      end else if (lk < 100) lk++;
      else lock_ok = 1'b1;
    end
  end

  // tester answers two cycles after test_start with the pattern bit of the tested phase
  initial begin
    logic [PB-1:0] ph;
    forever begin
      @(negedge clk);
      if (bus.test_start && int'(bus.psda) != no_ans) begin
        ph = bus.psda;
        repeat (2) @(negedge clk);
        t_pass = pattern[ph];
        t_done = 1'b1;
        @(negedge clk);
        t_done = 1'b0;
        t_pass = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string p);
    chk({p, "pll_reset"}, 32'(bus.pll_reset), 1);
    chk({p, "psda"}, 32'(bus.psda), 8);
    chk({p, "test_start"}, 32'(bus.test_start), 0);
    chk({p, "cal_busy"}, 32'(bus.cal_busy), 1);
    chk({p, "cal_done"}, 32'(bus.cal_done), 0);
    chk({p, "cal_fail"}, 32'(bus.cal_fail), 0);
    chk({p, "pass_map"}, 32'(bus.pass_map), 0);
    chk({p, "win_lo"}, 32'(bus.win_lo), 0);
    chk({p, "win_hi"}, 32'(bus.win_hi), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst_");
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.cal_busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(bus.cal_busy), 0);
  endtask

  task automatic wait_ts(input string tag, input int ph);
    int n = 0;
    while (!(bus.test_start && (ph < 0 || int'(bus.psda) == ph)) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < 3000), 1);
  endtask

  task automatic wait_psda(input string tag, input int ph);
    int n = 0;
    while (int'(bus.psda) != ph && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < 3000), 1);
  endtask

  initial begin
    int n;
    // single wide window 4..14
    do_reset();
    pattern = 16'h7FF0;
    n = 0;
    while (bus.pll_reset && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("pll_rst_len", 32'(n), RST);
    wait_idle("t1_idle");
    chk("t1_map", 32'(bus.pass_map), 32'h7FF0);
    chk("t1_lo", 32'(bus.win_lo), 4);
    chk("t1_hi", 32'(bus.win_hi), 14);
    chk("t1_psda", 32'(bus.psda), 9);
    chk("t1_done", 32'(bus.cal_done), 1);
    chk("t1_fail", 32'(bus.cal_fail), 0);
    // equal-length runs: lowest start wins
    do_reset();
    pattern = 16'h070E;
    wait_idle("t2_idle");
    chk("t2_map", 32'(bus.pass_map), 32'h070E);
    chk("t2_lo", 32'(bus.win_lo), 1);
    chk("t2_hi", 32'(bus.win_hi), 3);
    chk("t2_psda", 32'(bus.psda), 2);
    chk("t2_done", 32'(bus.cal_done), 1);
    // nothing passes
    do_reset();
    pattern = 16'h0000;
    wait_idle("t3_idle");
    chk("t3_fail", 32'(bus.cal_fail), 1);
    chk("t3_done", 32'(bus.cal_done), 0);
    chk("t3_psda", 32'(bus.psda), 8);
    chk("t3_map", 32'(bus.pass_map), 0);
    chk("t3_lo", 32'(bus.win_lo), 0);
    chk("t3_hi", 32'(bus.win_hi), 0);
    cal_start = 1'b1;
    @(negedge clk);
    cal_start = 1'b0;
    chk("t3_restart_busy", 32'(bus.cal_busy), 1);
    chk("t3_restart_fail", 32'(bus.cal_fail), 0);
    chk("t3_restart_pllrst", 32'(bus.pll_reset), 1);
    // lock never comes: periodic re-pulse
    lock_en = 1'b0;
    do_reset();
    n = 0;
    while (bus.pll_reset && n < 1000) begin
      @(negedge clk);
      n++;
    end
    while (!bus.pll_reset && n < 1000) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (bus.pll_reset && n < 1000) begin
      @(negedge clk);
      n++;
    end
    while (!bus.pll_reset && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("t4_period", 32'(n), RST + LTO + 1);
    chk("t4_busy", 32'(bus.cal_busy), 1);
    chk("t4_done", 32'(bus.cal_done), 0);
    lock_en = 1'b1;
    // lock loss at phase 6 coinciding with test_done
    do_reset();
    pattern = 16'h00FF;
    no_ans = 6;
    wait_ts("t5_ph6", 6);
    chk("t5_pre_map", 32'(bus.pass_map), 32'h003F);
    lock_drop = 1'b1;
    repeat (2) @(negedge clk);
    i_done = 1'b1;
    i_pass = 1'b1;
    @(negedge clk);
    i_done = 1'b0;
    i_pass = 1'b0;
    chk("t5_drop_pllrst", 32'(bus.pll_reset), 1);
    chk("t5_drop_map", 32'(bus.pass_map), 0);
    chk("t5_drop_busy", 32'(bus.cal_busy), 1);
    no_ans = -1;
    @(negedge clk);
    lock_drop = 1'b0;
    wait_ts("t5_first_ts", -1);
    chk("t5_restart_psda", 32'(bus.psda), 0);
    wait_idle("t5_idle");
    chk("t5_map", 32'(bus.pass_map), 32'h00FF);
    chk("t5_lo", 32'(bus.win_lo), 0);
    chk("t5_hi", 32'(bus.win_hi), 7);
    chk("t5_psda", 32'(bus.psda), 3);
    // tester silent at phase 3, then async reset mid-settle
    do_reset();
    pattern = 16'hFFFF;
    no_ans = 3;
    wait_psda("t6_ph4", 4);
    n = 0;
    while (!bus.test_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t6_settle_len", 32'(n), SET + 1);
    chk("t6_map_low", 32'(bus.pass_map[3:0]), 32'h7);
    wait_psda("t6_ph5", 5);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk_reset_vals("async_");
    @(negedge clk);
    reset = 1'b0;
    no_ans = -1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
